// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : lcd_pkg
//  Purpose   : Shared types and constants for the HD44780-style LCD
//              write controller (lcd_ctrl): FSM state encoding, phase
//              counter width, power-up init command table and the opcodes
//              that need the long execution wait.
//  Revision  : 1.0 - initial release
// ============================================================================
package lcd_pkg;

   // Controller states. PWRUP and INIT are only reachable when the
   // LCD_INIT_EN build option is enabled.
   typedef enum logic [2:0] {
      ST_PWRUP = 3'd0,
      ST_INIT  = 3'd1,
      ST_IDLE  = 3'd2,
      ST_SETUP = 3'd3,
      ST_PULSE = 3'd4,
      ST_HOLD  = 3'd5,
      ST_WAIT  = 3'd6
   } lcd_state_t;

   // Width of the shared phase counter; every timing parameter must fit.
   localparam int unsigned CNT_W = 20;

   // Power-up initialisation: function set (8-bit, 2 lines), display on,
   // clear, entry mode increment. Entry [0] is issued first.
   localparam int unsigned INIT_LEN = 4;
   localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

   // Instructions that need the long execution wait.
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;   // 0x03 is also "return home"

   // True for clear display and return home (bit 0 of home is don't-care).
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || ((data & ~8'h01) == CMD_HOME));
   endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : lcd_ctrl
//  Purpose   : Write-only controller for an HD44780-style character LCD.
//              Accepts one instruction/data byte per valid/ready handshake
//              and sequences RS/DB setup, the E strobe, hold time and the
//              command execution wait using one shared 20-bit down-counter.
//  Options   : `define LCD_INIT_EN to add the power-up delay and the
//              hardware init sequence (0x38, 0x0C, 0x01, 0x06). Without it
//              the controller comes out of reset ready and software is
//              responsible for initialising the panel.
//  Revision  : 1.0 - initial release
// ============================================================================
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC     = 2,
   parameter int unsigned EN_CYC        = 12,
   parameter int unsigned HOLD_CYC      = 2,
   parameter int unsigned EXEC_CYC      = 2000,
   parameter int unsigned LONG_EXEC_CYC = 82000,
   parameter int unsigned PWRUP_CYC     = 750000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_cmd_valid,
   input  logic       i_cmd_rs,
   input  logic [7:0] i_cmd_data,
   input  logic       i_lcd_on,
   output logic       o_cmd_ready,
   output logic [7:0] o_lcd_data,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic       o_lcd_en,
   output logic       o_lcd_on
);

   // Zero-length phases would never leave their state, and anything
   // wider than the counter would silently truncate.
   if ((SETUP_CYC == 0) || (EN_CYC == 0) || (HOLD_CYC == 0) ||
       (EXEC_CYC == 0) || (LONG_EXEC_CYC == 0) || (PWRUP_CYC == 0) ||
       (SETUP_CYC >= 2**CNT_W) || (EN_CYC >= 2**CNT_W) ||
       (HOLD_CYC >= 2**CNT_W) || (EXEC_CYC >= 2**CNT_W) ||
       (LONG_EXEC_CYC >= 2**CNT_W) || (PWRUP_CYC >= 2**CNT_W)) begin : g_param_check
      $error("lcd_ctrl: every timing parameter must lie in 1 .. 2**20-1");
   end

`ifdef LCD_INIT_EN
   localparam lcd_state_t RESET_STATE = ST_PWRUP;
`else
   localparam lcd_state_t RESET_STATE = ST_IDLE;
`endif

   lcd_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             lcd_on_q, lcd_on_d;

   // Where the FSM goes once a command's execution wait has elapsed.
   lcd_state_t       done_state;
   // Counter load for the WAIT phase (see note in the next-state logic).
   logic [CNT_W-1:0] wait_load;
   logic             cnt_last;

`ifdef LCD_INIT_EN
   // Index of the next init-table entry; INIT_LEN means the table is done.
   logic [2:0]       init_idx_q, init_idx_d;
`endif

   // Next-state, phase counter and byte latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rs_d     = rs_q;
      data_d   = data_q;
      lcd_on_d = i_lcd_on;
`ifdef LCD_INIT_EN
      init_idx_d = init_idx_q;
      done_state = (init_idx_q == 3'(INIT_LEN)) ? ST_IDLE : ST_INIT;
`else
      done_state = ST_IDLE;
`endif
      // The single IDLE cycle in which the next byte is taken counts as
      // the last cycle of the execution wait, so WAIT itself runs one
      // cycle short. That makes accept-to-accept spacing exactly
      // SETUP+EN+HOLD+exec when the host streams bytes back to back.
      wait_load = is_long_cmd(rs_q, data_q) ? CNT_W'(LONG_EXEC_CYC - 1)
                                            : CNT_W'(EXEC_CYC - 1);
      cnt_last  = (cnt_q == CNT_W'(1));

      case (state_q)
         ST_IDLE: begin
            if (i_cmd_valid) begin
               rs_d    = i_cmd_rs;
               data_d  = i_cmd_data;
               cnt_d   = CNT_W'(SETUP_CYC);
               state_d = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (cnt_last) begin
               cnt_d   = CNT_W'(EN_CYC);
               state_d = ST_PULSE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_PULSE: begin
            if (cnt_last) begin
               cnt_d   = CNT_W'(HOLD_CYC);
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_HOLD: begin
            if (cnt_last) begin
               if (wait_load == '0) begin
                  // A one-cycle execution time is covered by IDLE alone.
                  cnt_d   = '0;
                  state_d = done_state;
               end else begin
                  cnt_d   = wait_load;
                  state_d = ST_WAIT;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_WAIT: begin
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = done_state;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

`ifdef LCD_INIT_EN
         // Reset leaves the counter at zero, so the power-up delay counts
         // up from there instead of needing a load cycle.
         ST_PWRUP: begin
            if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
               cnt_d   = '0;
               state_d = ST_INIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Latch the next table entry as an instruction and send it through
         // the normal SETUP..WAIT sequence.
         ST_INIT: begin
            rs_d       = 1'b0;
            data_d     = INIT_CMDS[init_idx_q[1:0]];
            init_idx_d = init_idx_q + 3'd1;
            cnt_d      = CNT_W'(SETUP_CYC);
            state_d    = ST_SETUP;
         end
`endif

         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state, counter and latched byte; reset aborts any transfer.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
      end
   end

`ifdef LCD_INIT_EN
   // Init-table position, restarted by every reset.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         init_idx_q <= 3'd0;
      end else begin
         init_idx_q <= init_idx_d;
      end
   end
`endif

   // Panel power request is registered independently of the FSM.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         lcd_on_q <= 1'b0;
      end else begin
         lcd_on_q <= lcd_on_d;
      end
   end

   // E is a pure state decode, so reset drops it asynchronously.
   assign o_cmd_ready = (state_q == ST_IDLE);
   assign o_lcd_en    = (state_q == ST_PULSE);
   assign o_lcd_rs    = rs_q;
   assign o_lcd_data  = data_q;
   assign o_lcd_rw    = 1'b0;
   assign o_lcd_on    = lcd_on_q;

endmodule : lcd_ctrl
`default_nettype wire

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles RS/DATA are stable before EN rises.
REQ-002 Parameter EN_CYC, default 12: EN high width in cycles.
REQ-003 Parameter HOLD_CYC, default 2: cycles RS/DATA are held after EN falls.
REQ-004 Parameter EXEC_CYC, default 2000: post-command wait for normal commands and data (40 us at 50 MHz).
REQ-005 Parameter LONG_EXEC_CYC, default 82000: post-command wait for clear/home (1.64 ms).
REQ-006 Parameter PWRUP_CYC, default 750000: power-up delay (15 ms), used only when LCD_INIT_EN is defined.
REQ-007 i_clk  in  1  system clock, rising edge.
REQ-008 i_reset  in  1  asynchronous, active-low reset.
REQ-009 i_cmd_valid  in  1  a command or data byte is offered.
REQ-010 i_cmd_rs  in  1  0 = instruction, 1 = data.
REQ-011 i_cmd_data  in  8  byte to write.
REQ-012 i_lcd_on  in  1  panel power/backlight request (LSU LCD register bit 31).
REQ-013 o_cmd_ready  out  1  controller can accept a byte.
REQ-014 o_lcd_data  out  8  LCD DB[7:0].
REQ-015 o_lcd_rs  out  1  LCD RS.
REQ-016 o_lcd_rw  out  1  LCD RW, tied to 0 (write-only).
REQ-017 o_lcd_en  out  1  LCD E strobe.
REQ-018 o_lcd_on  out  1  registered copy of i_lcd_on.

Function
REQ-019 A byte is accepted on a rising edge where i_cmd_valid=1 and o_cmd_ready=1; RS and data are latched on that edge, and inputs are ignored at all other times.
REQ-020 FSM states: PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT; o_cmd_ready=1 only in IDLE.
REQ-021 Transitions:
- IDLE -> SETUP on accept.
- SETUP -> PULSE after SETUP_CYC cycles.
- PULSE -> HOLD after EN_CYC cycles.
- HOLD -> WAIT after HOLD_CYC cycles.
- WAIT -> IDLE (or INIT) after the exec count.
REQ-022 o_lcd_en=1 exactly in PULSE; o_lcd_data and o_lcd_rs hold the latched byte from SETUP through WAIT.
REQ-023 LONG_EXEC_CYC applies when rs=0 and data[7:2]=0 and data[1:0]!=0 (clear 0x01, home 0x02/0x03); EXEC_CYC applies otherwise.
REQ-024 Busy time from the accept edge to the next ready=1 is SETUP_CYC+EN_CYC+HOLD_CYC+exec cycles; back-to-back throughput is one byte per busy period.
REQ-025 Phase counter: 20-bit down-counter loaded on entry to each timed state; the state exits when the counter reaches 1; parameters of 0 are illegal.
REQ-026 i_cmd_valid held high while not ready causes no effect and no loss; the byte is accepted on the first ready cycle.
REQ-027 o_lcd_on follows i_lcd_on with 1-cycle latency, independent of FSM state.

Reset
REQ-028 On i_reset=0, asynchronously: o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_lcd_on=0, counter=0, init index=0.
REQ-029 The reset state is PWRUP if LCD_INIT_EN is defined, else IDLE, where o_cmd_ready=1 on the first cycle after release.
REQ-030 Reset mid-transfer aborts immediately: EN drops asynchronously, and no partial command is resumed.

Configuration
REQ-031 Macro LCD_INIT_EN defined:
- Reset enters PWRUP for PWRUP_CYC cycles, then INIT.
- INIT issues 0x38, 0x0C, 0x01, 0x06 (rs=0) in order, each through SETUP..WAIT with normal timing rules.
- After the 4th WAIT, the FSM enters IDLE.
- o_cmd_ready=0 throughout.
REQ-032 Macro LCD_INIT_EN undefined: the PWRUP/INIT logic and init table are absent, and the host software performs initialisation.

Structure
REQ-033 Package lcd_pkg holds the state enum typedef, the init-table constants (4 x 8 bit), CMD_CLEAR=0x01 and CMD_HOME=0x02.
REQ-034 Single module; no sub-module (the timer is inline).

Verification
Bench parameters: SETUP=2, EN=3, HOLD=2, EXEC=5, LONG=20, PWRUP=10.
REQ-035 Without the macro, send rs=1, data=0x41 -> EN high exactly 3 cycles with DB=0x41 and RS=1 stable from 2 cycles before to 2 after; ready returns 12 cycles after the accept edge.
REQ-036 Send rs=0, data=0x01 -> ready returns 27 cycles after accept; rs=0, data=0x80 -> 12 cycles.
REQ-037 Valid held high for three back-to-back bytes 0x48, 0x49, 0x21 -> three EN pulses 12 cycles apart, in order, none dropped or duplicated.
REQ-038 With LCD_INIT_EN: release reset -> ready=0, first EN after 10+2 cycles, DB sequence 0x38, 0x0C, 0x01, 0x06, then ready=1; a valid offered during init is accepted only afterwards.
REQ-039 Assert reset during PULSE -> EN=0 in the same cycle and all outputs at reset values; after release the next byte transfers normally.
